bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter N, default 16: binary input width, legal range 4..32.
REQ-002 Parameter DIGITS, default 5: BCD output digit count; SHALL satisfy 10^DIGITS > 2^N - 1, checked by an elaboration-time assertion.
REQ-003 Parameter SIGNED, default 0: 0 = bin is unsigned; 1 = bin is two's complement.
REQ-004 clk  in  1  rising-edge clock; sole clock domain.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  conversion request; sampled only in IDLE.
REQ-007 bin  in  N  value to convert; sampled on the edge that accepts start.
REQ-008 busy  out  1  high while a conversion is in progress.
REQ-009 done  out  1  one-cycle pulse when result registers update.
REQ-010 bcd  out  4*DIGITS  result digits; digit k in bits [4k+3:4k], digit 0 least significant.
REQ-011 neg  out  1  sign of the converted value; always 0 when SIGNED=0.
REQ-012 ndig  out  $clog2(DIGITS+1)  count of significant digits, leading zeros excluded, minimum 1.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-014 In IDLE with start=1 on edge E0, the block SHALL capture the magnitude of bin, clear the BCD scratch register, load the bit counter with N, set busy=1 and enter SHIFT.
REQ-015 Magnitude rules:
- SIGNED=0: magnitude = bin.
- SIGNED=1 and bin[N-1]=1: magnitude = two's complement negation of bin as an N-bit unsigned value, so -2^(N-1) converts to 2^(N-1).
REQ-016 Each SHIFT cycle, every scratch digit >= 5 SHALL be incremented by 3 first; the {scratch, magnitude} register SHALL then shift left by 1 in the same edge (double-dabble). Corrections to all digits SHALL be applied in one cycle.
REQ-017 On the N-th SHIFT edge (EN), the block SHALL load bcd, neg and ndig from the final result, set done=1, set busy=0 and enter DONE.
REQ-018 On the next edge (EN+1), the block SHALL clear done and return to IDLE.
REQ-019 Latency: done is high for exactly the cycle between EN and EN+1, which is N edges after E0. Throughput: one conversion per N+2 cycles.
REQ-020 start SHALL be ignored in SHIFT and DONE; no queuing and no effect on the running conversion. bin changes after E0 SHALL have no effect.
REQ-021 bcd, neg and ndig SHALL hold their last values from the EN update until the next EN; intermediate scratch values SHALL never appear on the outputs.
REQ-022 ndig SHALL be 1 + the index of the highest nonzero digit, or 1 if the result is 0.
REQ-023 neg SHALL be 1 only if SIGNED=1 and the sampled bin[N-1]=1.
REQ-024 A start held high continuously SHALL produce back-to-back conversions, each accepted in IDLE, one every N+2 cycles.

Reset
REQ-025 While rst=0, regardless of clk, the block SHALL force: state=IDLE, busy=0, done=0, bcd=0, neg=0, ndig=1, counter=0, scratch=0.
REQ-026 Reset asserted mid-conversion SHALL abort the conversion with no done pulse. The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- N=16, DIGITS=5, SIGNED=0, bin=65535, start pulsed at E0 -> done only between E16 and E17; bcd=0x65535; ndig=5; neg=0.
- Same configuration, bin=0 -> bcd=0x00000; ndig=1; done asserted exactly once.
- N=8, DIGITS=3, SIGNED=1, bin=8'h80 -> bcd=0x128, neg=1, ndig=3. Then bin=8'hFF -> bcd=0x001, neg=1, ndig=1.
- N=16 configuration, bin=1234; start re-pulsed at E5 with bin=9999 -> that start is ignored; result bcd=0x01234, ndig=4. Outputs stay stable until the next accepted conversion completes.
- rst pulsed low at E8 of a conversion -> all outputs reset immediately; no done pulse. A new start with bin=42 then yields bcd=0x00042, ndig=2.
- start held high for 3 conversions -> done pulses spaced exactly N+2 cycles apart; busy=0 only in the IDLE and DONE cycles.

Source files
------------

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle for the sequential binary-to-BCD converter.
interface bin2bcd_seq_if #(
    parameter int unsigned N      = 16,
    parameter int unsigned DIGITS = 5
);
    localparam int unsigned NdW = $clog2(DIGITS + 1);

    logic                  start;
    logic [N-1:0]          bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  neg;
    logic [NdW-1:0]        ndig;

    // Requester side drives start/bin and observes the result.
    modport master (
        output start, bin,
        input  busy, done, bcd, neg, ndig
    );

    // Converter side.
    modport slave (
        input  start, bin,
        output busy, done, bcd, neg, ndig
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one input bit per cycle,
// N shift cycles per conversion, results held in output registers between
// conversions.
module bin2bcd_seq #(
    parameter int unsigned N      = 16,
    parameter int unsigned DIGITS = 5,
    parameter int unsigned SIGNED = 0
) (
    input logic           clk_i,
    input logic           rst_ni,
    bin2bcd_seq_if.slave  bus_io
);
    localparam int unsigned NdW  = $clog2(DIGITS + 1);
    localparam int unsigned CntW = $clog2(N + 1);
    localparam int unsigned BcdW = 4 * DIGITS;

    // True when DIGITS decimal digits can hold the largest N-bit magnitude.
    function automatic logic digits_fit();
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < DIGITS; i++) p = p * 64'd10;
        return p > ((64'd1 << N) - 64'd1);
    endfunction

    if (N < 4 || N > 32) begin : g_bad_n
        $error("bin2bcd_seq: N must be in 4..32");
    end
    if (!digits_fit()) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS too small for N-bit input");
    end

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic [N-1:0]      mag_q, mag_d;
    logic [BcdW-1:0]   scratch_q, scratch_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              sign_q, sign_d;
    logic [BcdW-1:0]   bcd_q, bcd_d;
    logic              neg_q, neg_d;
    logic [NdW-1:0]    ndig_q, ndig_d;

    logic              in_neg;
    logic [N-1:0]      in_mag;
    logic [BcdW-1:0]   corr;
    logic [BcdW-1:0]   sh_scratch;
    logic [N-1:0]      sh_mag;
    logic [NdW-1:0]    ndig_calc;

    // Input magnitude; the most negative value negates to 2^(N-1) as unsigned.
    always_comb begin
        in_neg = (SIGNED != 0) && bus_io.bin[N-1];
        in_mag = in_neg ? -bus_io.bin : bus_io.bin;
    end

    // One double-dabble step: +3 on every digit >= 5, then shift the pair left.
    always_comb begin
        corr = scratch_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) corr[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
        end
        sh_scratch = (corr << 1) | {{(BcdW-1){1'b0}}, mag_q[N-1]};
        sh_mag     = mag_q << 1;
        ndig_calc  = NdW'(1);
        for (int k = 0; k < DIGITS; k++) begin
            if (sh_scratch[4*k +: 4] != 4'd0) ndig_calc = NdW'(k + 1);
        end
    end

    // Next-state and datapath updates for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        bcd_d     = bcd_q;
        neg_d     = neg_q;
        ndig_d    = ndig_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    mag_d     = in_mag;
                    sign_d    = in_neg;
                    scratch_d = '0;
                    cnt_d     = CntW'(N);
                    state_d   = StShift;
                end
            end
            StShift: begin
                scratch_d = sh_scratch;
                mag_d     = sh_mag;
                cnt_d     = cnt_q - CntW'(1);
                // Last bit: publish the finished result in the same edge.
                if (cnt_q == CntW'(1)) begin
                    bcd_d   = sh_scratch;
                    neg_d   = sign_q;
                    ndig_d  = ndig_calc;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // Working and result registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mag_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
            ndig_q    <= NdW'(1);
        end else begin
            mag_q     <= mag_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            bcd_q     <= bcd_d;
            neg_q     <= neg_d;
            ndig_q    <= ndig_d;
        end
    end

    assign bus_io.busy = (state_q == StShift);
    assign bus_io.done = (state_q == StDone);
    assign bus_io.bcd  = bcd_q;
    assign bus_io.neg  = neg_q;
    assign bus_io.ndig = ndig_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: an unsigned 16-bit/5-digit instance and a signed
// 8-bit/3-digit instance, table vectors plus directed multi-cycle sequences.
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bin2bcd_seq_if #(.N(16), .DIGITS(5)) a_if ();
    bin2bcd_seq_if #(.N(8),  .DIGITS(3)) b_if ();

    bin2bcd_seq #(.N(16), .DIGITS(5), .SIGNED(0)) u_a (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus_io(a_if)
    );
    bin2bcd_seq #(.N(8), .DIGITS(3), .SIGNED(1)) u_b (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus_io(b_if)
    );

    typedef struct {
        logic [15:0] bin;
        logic [19:0] bcd;
        logic [2:0]  ndig;
    } vec16_t;
    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
        logic        neg;
        logic [1:0]  ndig;
    } vec8_t;
    typedef struct {
        logic [19:0] bcd;
        logic        neg;
        logic [2:0]  ndig;
    } exp_t;

    exp_t   sb_q[$];
    vec16_t tbl16[$];
    vec8_t  tbl8[$];

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt16 = 0;

    always @(posedge clk) if (a_if.done === 1'b1) done_cnt16 <= done_cnt16 + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference by repeated division, independent of the shift-add method.
    function automatic logic [19:0] model_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [2:0] model_ndig(input logic [19:0] b);
        logic [2:0] n;
        n = 3'd1;
        for (int k = 0; k < 5; k++) if (b[4*k +: 4] != 4'd0) n = 3'(k + 1);
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_cmp(input string tag, input logic [19:0] bcd, input logic neg,
                           input logic [2:0] ndig);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(1), 64'(0));
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_bcd"}, 64'(bcd), 64'(e.bcd));
            chk({tag, "_neg"}, 64'(neg), 64'(e.neg));
            chk({tag, "_ndig"}, 64'(ndig), 64'(e.ndig));
        end
    endtask

    task automatic conv16(input logic [15:0] b, input logic [19:0] eb, input logic [2:0] en);
        exp_t e;
        int   cyc;
        int   dc0;
        e.bcd = eb; e.neg = 1'b0; e.ndig = en;
        sb_q.push_back(e);
        dc0 = done_cnt16;
        a_if.start = 1'b1;
        a_if.bin   = b;
        tick();
        a_if.start = 1'b0;
        a_if.bin   = 16'($urandom);
        chk("busy16_after_accept", 64'(a_if.busy), 64'(1));
        cyc = 0;
        while (a_if.done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("latency16", 64'(cyc), 64'(16));
        chk("busy16_in_done", 64'(a_if.busy), 64'(0));
        pop_cmp("conv16", a_if.bcd, a_if.neg, a_if.ndig);
        tick();
        chk("done16_clear", 64'(a_if.done), 64'(0));
        chk("done16_once", 64'(done_cnt16 - dc0), 64'(1));
    endtask

    task automatic conv8(input vec8_t v);
        exp_t e;
        int   cyc;
        e.bcd = {8'h00, v.bcd}; e.neg = v.neg; e.ndig = {1'b0, v.ndig};
        sb_q.push_back(e);
        b_if.start = 1'b1;
        b_if.bin   = v.bin;
        tick();
        b_if.start = 1'b0;
        b_if.bin   = 8'($urandom);
        cyc = 0;
        while (b_if.done !== 1'b1 && cyc < 30) begin
            tick();
            cyc++;
        end
        chk("latency8", 64'(cyc), 64'(8));
        pop_cmp("conv8", {8'h00, b_if.bcd}, b_if.neg, {1'b0, b_if.ndig});
        tick();
        chk("done8_clear", 64'(b_if.done), 64'(0));
    endtask

    initial begin
        vec16_t v;
        vec8_t  w;
        exp_t   e;
        int     cyc, dc0, act, ndone, last, busy_lo;
        logic [15:0] r;

        tbl16.push_back('{16'd65535, 20'h65535, 3'd5});
        tbl16.push_back('{16'd0,     20'h00000, 3'd1});
        tbl16.push_back('{16'd9,     20'h00009, 3'd1});
        tbl16.push_back('{16'd10,    20'h00010, 3'd2});
        tbl16.push_back('{16'd99,    20'h00099, 3'd2});
        tbl16.push_back('{16'd100,   20'h00100, 3'd3});
        tbl16.push_back('{16'd10000, 20'h10000, 3'd5});
        tbl16.push_back('{16'd32768, 20'h32768, 3'd5});
        for (int i = 0; i < 3; i++) begin
            r = 16'($urandom);
            v.bin = r; v.bcd = model_bcd(32'(r)); v.ndig = model_ndig(v.bcd);
            tbl16.push_back(v);
        end
        tbl8.push_back('{8'h80, 12'h128, 1'b1, 2'd3});
        tbl8.push_back('{8'hFF, 12'h001, 1'b1, 2'd1});
        tbl8.push_back('{8'h7F, 12'h127, 1'b0, 2'd3});
        tbl8.push_back('{8'h00, 12'h000, 1'b0, 2'd1});
        tbl8.push_back('{8'hF6, 12'h010, 1'b1, 2'd2});

        a_if.start = 1'b0; a_if.bin = '0;
        b_if.start = 1'b0; b_if.bin = '0;

        // Reset state.
        tick(); tick();
        chk("rst_busy", 64'(a_if.busy), 64'(0));
        chk("rst_done", 64'(a_if.done), 64'(0));
        chk("rst_bcd", 64'(a_if.bcd), 64'(0));
        chk("rst_neg", 64'(a_if.neg), 64'(0));
        chk("rst_ndig", 64'(a_if.ndig), 64'(1));
        chk("rst_ndig8", 64'(b_if.ndig), 64'(1));
        rst_n = 1'b1;
        tick();

        foreach (tbl16[i]) conv16(tbl16[i].bin, tbl16[i].bcd, tbl16[i].ndig);
        foreach (tbl8[i]) begin
            w = tbl8[i];
            conv8(w);
        end

        // Start re-pulsed mid-conversion must be ignored; result held afterwards.
        dc0 = done_cnt16;
        a_if.start = 1'b1; a_if.bin = 16'd1234;
        tick();
        a_if.start = 1'b0;
        cyc = 0;
        while (a_if.done !== 1'b1 && cyc < 40) begin
            if (cyc == 4) begin
                a_if.start = 1'b1; a_if.bin = 16'd9999;
            end else begin
                a_if.start = 1'b0;
            end
            if (cyc == 8) chk("hold_mid_conv", 64'(a_if.bcd), 64'(tbl16[tbl16.size()-1].bcd));
            tick();
            cyc++;
        end
        a_if.start = 1'b0;
        chk("repulse_latency", 64'(cyc), 64'(16));
        chk("repulse_bcd", 64'(a_if.bcd), 64'(20'h01234));
        chk("repulse_ndig", 64'(a_if.ndig), 64'(4));
        act = 0;
        tick();
        for (int i = 0; i < 6; i++) begin
            if (a_if.busy === 1'b1 || a_if.done === 1'b1) act++;
            tick();
        end
        chk("repulse_no_queue", 64'(act), 64'(0));
        chk("repulse_bcd_hold", 64'(a_if.bcd), 64'(20'h01234));
        chk("repulse_done_once", 64'(done_cnt16 - dc0), 64'(1));

        // Reset in the middle of a conversion aborts it with no done pulse.
        a_if.start = 1'b1; a_if.bin = 16'd7777;
        tick();
        a_if.start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        dc0 = done_cnt16;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("abort_busy", 64'(a_if.busy), 64'(0));
        chk("abort_done", 64'(a_if.done), 64'(0));
        chk("abort_bcd", 64'(a_if.bcd), 64'(0));
        chk("abort_neg", 64'(a_if.neg), 64'(0));
        chk("abort_ndig", 64'(a_if.ndig), 64'(1));
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("abort_no_done", 64'(done_cnt16 - dc0), 64'(0));
        conv16(16'd42, 20'h00042, 3'd2);

        // Start held high: back-to-back conversions every N+2 cycles.
        for (int i = 0; i < 3; i++) begin
            e.bcd = 20'h00500; e.neg = 1'b0; e.ndig = 3'd3;
            sb_q.push_back(e);
        end
        a_if.bin = 16'd500; a_if.start = 1'b1;
        ndone = 0; cyc = 0; last = 0; busy_lo = 0;
        while (ndone < 3 && cyc < 100) begin
            tick();
            cyc++;
            if (a_if.done === 1'b1) begin
                if (ndone > 0) chk("b2b_spacing", 64'(cyc - last), 64'(18));
                chk("b2b_busy_low", 64'(a_if.busy), 64'(0));
                pop_cmp("b2b", a_if.bcd, a_if.neg, a_if.ndig);
                last = cyc;
                ndone++;
                if (ndone == 3) a_if.start = 1'b0;
            end
            if (ndone >= 1 && a_if.busy !== 1'b1) busy_lo++;
        end
        a_if.start = 1'b0;
        chk("b2b_count", 64'(ndone), 64'(3));
        chk("b2b_idle_cycles", 64'(busy_lo), 64'(5));
        chk("b2b_first_latency", 64'(cyc - 36), 64'(17));
        tick(); tick();
        chk("b2b_idle_after", 64'(a_if.busy), 64'(0));
        chk("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
